// File: rtl/banner_pkg.sv
// banner_pkg: shared state type, screen limits and coordinate helpers for the banner driver
package banner_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W = 11;
  typedef enum logic [1:0] {IDLE, SLIDE, BLINK, HOLD} banner_state_t;
  function automatic logic [COORD_W-1:0] sat_add(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] step, input logic [COORD_W-1:0] lim);
    logic [COORD_W:0] s;
    s = {1'b0, a} + {1'b0, step};
    return (s >= {1'b0, lim}) ? lim : s[COORD_W-1:0];
  endfunction
endpackage

// File: rtl/frame_tick_counter.sv
// frame_tick_counter: counts tick_i pulses, pulses expired_o on the limit_i-th tick and wraps; clr_i holds it at zero
// Ports: clk, reset (async, high), clr_i (sync clear), tick_i (frame pulse), limit_i (ticks per period), expired_o (one-cycle pulse)
module frame_tick_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         tick_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign expired_o = tick_i && !clr_i && (cnt_q == limit_i - W'(1));
  always_comb cnt_d = clr_i ? '0 : !tick_i ? cnt_q : expired_o ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/banner_rect_driver.sv
// banner_rect_driver: registered box test/offsets for a banner bitmap plus a per-frame slide/blink/hold animation
// Ports: clk, reset (async, high), pixelX/pixelY (pixel coords), startOfFrame (frame pulse), show (banner request),
//   offsetX/offsetY (in-box offsets, 0 outside), InsideRectangle, draw (bitmap enable), done (animation in HOLD)
// Build option: BANNER_BLINK_EN compiles in the BLINK phase; without it the slide ends directly in HOLD
module banner_rect_driver
  import banner_pkg::*;
#(
  parameter int OBJECT_WIDTH_X = 80,
  parameter int OBJECT_HEIGHT_Y = 20,
  parameter int FINAL_X = 280,
  parameter int START_Y = 0,
  parameter int FINAL_Y = 230,
  parameter int SLIDE_STEP = 4,
  parameter int BLINK_FRAMES = 15,
  parameter int BLINK_COUNT = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic               startOfFrame,
  input  logic               show,
  output logic [COORD_W-1:0] offsetX,
  output logic [COORD_W-1:0] offsetY,
  output logic               InsideRectangle,
  output logic               draw,
  output logic               done
);
  if (FINAL_X + OBJECT_WIDTH_X > SCREEN_W || FINAL_Y + OBJECT_HEIGHT_Y > SCREEN_H ||
      BLINK_FRAMES < 1 || BLINK_COUNT < 1 || SLIDE_STEP < 1) begin : g_cfg_err
    $error("banner_rect_driver: invalid configuration");
  end
  banner_state_t state_q, state_d;
  logic [COORD_W-1:0] top_q, top_d, offx_q, offy_q;
  logic draw_q, draw_d, ins_q, ins_d;
  logic [COORD_W:0] px, py, ty;
`ifdef BANNER_BLINK_EN
  localparam int TOGS = 2 * BLINK_COUNT;
  logic half_exp;
  logic [7:0] tog_q, tog_d;
  frame_tick_counter #(.W(8)) u_blink (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (state_q != BLINK),
    .tick_i   (startOfFrame),
    .limit_i  (8'(BLINK_FRAMES)),
    .expired_o(half_exp)
  );
`endif
  always_comb begin
    state_d = state_q;
    top_d = top_q;
    draw_d = draw_q;
`ifdef BANNER_BLINK_EN
    tog_d = tog_q;
`endif
    if (!show) begin
      state_d = IDLE;
      top_d = COORD_W'(START_Y);
      draw_d = 1'b0;
`ifdef BANNER_BLINK_EN
      tog_d = '0;
`endif
    end else if (startOfFrame) begin
      case (state_q)
        IDLE: begin
          state_d = SLIDE;
          draw_d = 1'b1;
        end
        SLIDE: begin
          top_d = sat_add(top_q, COORD_W'(SLIDE_STEP), COORD_W'(FINAL_Y));
`ifdef BANNER_BLINK_EN
          if (top_d == COORD_W'(FINAL_Y)) state_d = BLINK;
`else
          if (top_d == COORD_W'(FINAL_Y)) state_d = HOLD;
`endif
        end
`ifdef BANNER_BLINK_EN
        BLINK: if (half_exp) begin
          draw_d = !draw_q;
          tog_d = tog_q + 8'd1;
          if (tog_q == 8'(TOGS - 1)) state_d = HOLD;
        end
`endif
        default: ;
      endcase
    end
  end
  // 12-bit compares so FINAL_X+width or topY+height can never wrap
  assign px = {1'b0, pixelX};
  assign py = {1'b0, pixelY};
  assign ty = {1'b0, top_q};
  assign ins_d = px >= (COORD_W+1)'(FINAL_X) && px < (COORD_W+1)'(FINAL_X + OBJECT_WIDTH_X) &&
                 py >= ty && py < ty + (COORD_W+1)'(OBJECT_HEIGHT_Y);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      top_q <= COORD_W'(START_Y);
      draw_q <= 1'b0;
      ins_q <= 1'b0;
      offx_q <= '0;
      offy_q <= '0;
`ifdef BANNER_BLINK_EN
      tog_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      top_q <= top_d;
      draw_q <= draw_d;
      ins_q <= ins_d;
      offx_q <= ins_d ? pixelX - COORD_W'(FINAL_X) : '0;
      offy_q <= ins_d ? pixelY - top_q : '0;
`ifdef BANNER_BLINK_EN
      tog_q <= tog_d;
`endif
    end
  assign offsetX = offx_q;
  assign offsetY = offy_q;
  assign InsideRectangle = ins_q;
  assign draw = draw_q;
  assign done = state_q == HOLD;
endmodule

// File: tb/tb_banner_rect_driver.sv
// tb_banner_rect_driver: scoreboard bench for banner_rect_driver (box test, slide, blink/hold, abort, reset)
module tb_banner_rect_driver;
  logic clk = 1'b0, reset, sof, show;
  logic [10:0] px, py, offsetX, offsetY;
  logic InsideRectangle, draw, done;
  int total = 0, bad = 0, ty;
  typedef struct {string tag; int sel; logic [31:0] v;} exp_t;
  exp_t sb[$];
  banner_rect_driver dut (
    .clk(clk), .reset(reset), .pixelX(px), .pixelY(py), .startOfFrame(sof), .show(show),
    .offsetX(offsetX), .offsetY(offsetY), .InsideRectangle(InsideRectangle), .draw(draw), .done(done)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0: return 32'(InsideRectangle);
      1: return 32'(offsetX);
      2: return 32'(offsetY);
      3: return 32'(draw);
      default: return 32'(done);
    endcase
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic want(input string tag, input int sel, input int v);
    sb.push_back('{tag, sel, 32'(v)});
  endtask
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.sel), e.v);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1 drain();
  endtask
  task automatic frame();
    sof = 1'b1;
    step();
    sof = 1'b0;
  endtask
  task automatic probe(input string tag, input int x, input int y, input int ins, input int ox, input int oy);
    px = 11'(x);
    py = 11'(y);
    want({tag, "_in"}, 0, ins);
    want({tag, "_ox"}, 1, ox);
    want({tag, "_oy"}, 2, oy);
    step();
  endtask
  task automatic want_dd(input string tag, input int d, input int dn);
    want({tag, "_draw"}, 3, d);
    want({tag, "_done"}, 4, dn);
  endtask
  initial begin
    reset = 1'b1; sof = 1'b0; show = 1'b0; px = 11'd300; py = 11'd5;
    repeat (2) @(posedge clk);
    #1;
    want("rst_in", 0, 0); want("rst_ox", 1, 0); want("rst_oy", 2, 0); want_dd("rst", 0, 0);
    drain();
    reset = 1'b0;
    repeat (2) begin
      want_dd("idle", 0, 0);
      frame();
      step();
    end
    probe("first", 300, 5, 1, 20, 5);
    show = 1'b1;
    want_dd("enter", 1, 0);
    frame();
    ty = 0;
    for (int k = 1; k <= 58; k++) begin
      ty = (ty + 4 > 230) ? 230 : ty + 4;
`ifdef BANNER_BLINK_EN
      want_dd("slide", 1, 0);
`else
      want_dd("slide", 1, k == 58 ? 1 : 0);
`endif
      frame();
      probe("top", 300, ty, 1, 20, 0);
      probe("above", 300, ty - 1, 0, 0, 0);
    end
    probe("e279", 279, 235, 0, 0, 0);
    probe("e280", 280, 230, 1, 0, 0);
    probe("e359", 359, 249, 1, 79, 19);
    probe("e360", 360, 249, 0, 0, 0);
    probe("ebot", 300, 250, 0, 0, 0);
`ifdef BANNER_BLINK_EN
    for (int f = 1; f <= 90; f++) begin
      want_dd("blink", ((f / 15) % 2 == 0) ? 1 : 0, f == 90 ? 1 : 0);
      frame();
    end
`else
    for (int f = 1; f <= 20; f++) begin
      want_dd("hold", 1, 1);
      frame();
    end
`endif
    show = 1'b0;
    want_dd("abort1", 0, 0);
    step();
    probe("abort1_top", 300, 0, 1, 20, 0);
    show = 1'b1;
    want_dd("restart", 1, 0);
    frame();
    for (int k = 1; k <= 58; k++) frame();
`ifdef BANNER_BLINK_EN
    for (int f = 1; f <= 20; f++) begin
      want_dd("blink2", f >= 15 ? 0 : 1, 0);
      frame();
    end
`else
    want_dd("hold2", 1, 1);
    step();
`endif
    show = 1'b0;
    want_dd("abort2", 0, 0);
    step();
    probe("abort2_top", 300, 0, 1, 20, 0);
    show = 1'b1;
    frame();
    frame();
    probe("reslide_in", 300, 4, 1, 20, 0);
    probe("reslide_out", 300, 3, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    want("areset_in", 0, 0);
    want_dd("areset", 0, 0);
    drain();
    reset = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
